// File: rtl/uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// uart_reg_bridge
//
// Byte-level command decoder between the UART receiver and transmitter of the
// NCO design. Decodes write ('W', addr, D3..D0) and read ('R', addr) packets
// into a 4-entry, 32-bit control register file and answers each packet with
// either an acknowledge byte ('K'), four readback bytes (MSB first) or a NAK
// byte ('?').
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   rx_byte      in   received byte, valid when rbyte_ready=1
//   rbyte_ready  in   one-cycle strobe, new byte available
//   busy         in   UART transmitter busy (rises the cycle after send)
//   sbyte        out  byte to transmit, stable while send=1
//   send         out  one-cycle transmit strobe
//   freq_word    out  register 0, NCO frequency word
//   phase_ofs    out  register 1, phase offset
//   amplitude    out  register 2, amplitude
//   control      out  register 3, control
//   cfg_update   out  one-cycle pulse the cycle after any register write
//   pkt_err      out  one-cycle pulse on a bad address or inter-byte timeout
// -----------------------------------------------------------------------------
module uart_reg_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [31:0] FREQ_DEFAULT   = 32'h0147AE14,
  parameter logic [31:0] AMP_DEFAULT    = 32'h00007FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rbyte_ready,
  input  logic        busy,
  output logic [7:0]  sbyte,
  output logic        send,
  output logic [31:0] freq_word,
  output logic [31:0] phase_ofs,
  output logic [31:0] amplitude,
  output logic [31:0] control,
  output logic        cfg_update,
  output logic        pkt_err
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_NAK   = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    EXEC,
    TX_LOAD,
    TX_GUARD,
    TX_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   asm_q, asm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   regs_q [4];
  logic [31:0]   regs_d [4];
  logic [31:0]   tx_buf_q, tx_buf_d;
  logic [2:0]    tx_cnt_q, tx_cnt_d;
  logic [7:0]    sbyte_q, sbyte_d;
  logic          send_q, send_d;
  logic          cfg_update_q, cfg_update_d;
  logic          pkt_err_q, pkt_err_d;

  logic in_pkt;
  logic timeout_hit;
  logic addr_ok;

  // Only ADDR/DATA wait on the host; a byte arriving on the expiry cycle wins.
  assign in_pkt      = (state_q == ADDR) || (state_q == DATA);
  assign timeout_hit = in_pkt && !rbyte_ready && (cnt_q == CNT_MAX);
  assign addr_ok     = (addr_q[7:2] == 6'd0);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: every flop is updated with <= so all of them sample the values
    // computed in the previous cycle, independent of statement order.
    if (reset) begin
      state_q      <= IDLE;
      is_wr_q      <= 1'b0;
      addr_q       <= 8'h00;
      idx_q        <= 2'd0;
      asm_q        <= 32'h0;
      cnt_q        <= '0;
      // NOTE: the register file is reset because it drives the NCO directly;
      // it is only four words, so per-entry reset values are cheap and needed.
      regs_q[0]    <= FREQ_DEFAULT;
      regs_q[1]    <= 32'h0;
      regs_q[2]    <= AMP_DEFAULT;
      regs_q[3]    <= 32'h0;
      tx_buf_q     <= 32'h0;
      tx_cnt_q     <= 3'd0;
      sbyte_q      <= 8'h00;
      send_q       <= 1'b0;
      cfg_update_q <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      cnt_q        <= cnt_d;
      regs_q       <= regs_d;
      tx_buf_q     <= tx_buf_d;
      tx_cnt_q     <= tx_cnt_d;
      sbyte_q      <= sbyte_d;
      send_q       <= send_d;
      cfg_update_q <= cfg_update_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default on entry means every path assigns state_d, so no latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rbyte_ready && (rx_byte == CMD_WRITE || rx_byte == CMD_READ)) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (rbyte_ready) begin
          state_d = is_wr_q ? DATA : EXEC;
        end
      end
      DATA: begin
        if (timeout_hit) begin
          state_d = IDLE;
        end else if (rbyte_ready && idx_q == 2'd3) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = TX_LOAD;
      end
      TX_LOAD: begin
        if (!busy) begin
          state_d = TX_GUARD;
        end
      end
      // busy only rises the cycle after send, so it is not trusted here.
      TX_GUARD: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!busy) begin
          state_d = (tx_cnt_q != 3'd0) ? TX_LOAD : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    idx_d        = idx_q;
    asm_d        = asm_q;
    regs_d       = regs_q;
    tx_buf_d     = tx_buf_q;
    tx_cnt_d     = tx_cnt_q;
    sbyte_d      = sbyte_q;
    send_d       = 1'b0;
    cfg_update_d = 1'b0;
    pkt_err_d    = timeout_hit;

    // Counter runs only while a packet is being assembled; any byte clears it.
    if (in_pkt && !rbyte_ready && !timeout_hit) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = '0;
    end

    unique case (state_q)
      IDLE: begin
        if (rbyte_ready) begin
          is_wr_d = (rx_byte == CMD_WRITE);
        end
      end
      ADDR: begin
        if (rbyte_ready) begin
          addr_d = rx_byte;
          idx_d  = 2'd0;
        end
      end
      DATA: begin
        if (rbyte_ready) begin
          asm_d = {asm_q[23:0], rx_byte};
          idx_d = idx_q + 2'd1;
        end
      end
      EXEC: begin
        if (!addr_ok) begin
          pkt_err_d = 1'b1;
          tx_buf_d  = {RSP_NAK, 24'h0};
          tx_cnt_d  = 3'd1;
        end else if (is_wr_q) begin
          regs_d[addr_q[1:0]] = asm_q;
          cfg_update_d        = 1'b1;
          tx_buf_d            = {RSP_ACK, 24'h0};
          tx_cnt_d            = 3'd1;
        end else begin
          // Snapshot taken here so the readback cannot tear.
          tx_buf_d = regs_q[addr_q[1:0]];
          tx_cnt_d = 3'd4;
        end
      end
      TX_LOAD: begin
        if (!busy) begin
          send_d   = 1'b1;
          sbyte_d  = tx_buf_q[31:24];
          tx_buf_d = {tx_buf_q[23:0], 8'h00};
          tx_cnt_d = tx_cnt_q - 3'd1;
        end
      end
      default: begin
      end
    endcase
  end

  assign sbyte      = sbyte_q;
  assign send       = send_q;
  assign cfg_update = cfg_update_q;
  assign pkt_err    = pkt_err_q;
  assign freq_word  = regs_q[0];
  assign phase_ofs  = regs_q[1];
  assign amplitude  = regs_q[2];
  assign control    = regs_q[3];

endmodule

// File: tb/tb_uart_reg_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_reg_bridge
//
// Directed bench for uart_reg_bridge. Stimulus tasks push the expected
// transmit bytes into a queue; a monitor on the falling edge pops and compares
// each byte the DUT sends, and also counts cfg_update / pkt_err pulses.
// A small UART transmitter model raises busy the cycle after send.
// -----------------------------------------------------------------------------
module tb_uart_reg_bridge;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rbyte_ready = 1'b0;
  logic        busy;
  logic [7:0]  sbyte;
  logic        send;
  logic [31:0] freq_word, phase_ofs, amplitude, control;
  logic        cfg_update, pkt_err;

  uart_reg_bridge #(
    .TIMEOUT_CYCLES(TO),
    .FREQ_DEFAULT  (32'h0147AE14),
    .AMP_DEFAULT   (32'h00007FFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rbyte_ready(rbyte_ready),
    .busy       (busy),
    .sbyte      (sbyte),
    .send       (send),
    .freq_word  (freq_word),
    .phase_ofs  (phase_ofs),
    .amplitude  (amplitude),
    .control    (control),
    .cfg_update (cfg_update),
    .pkt_err    (pkt_err)
  );

  always #5 clk = ~clk;

  // UART transmitter model: busy for 4 cycles starting the cycle after send.
  // It ignores reset, since a byte already handed over keeps going out.
  logic [2:0] busy_cnt = 3'd0;
  always @(posedge clk) begin
    if (send) busy_cnt <= 3'd4;
    else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
  end
  assign busy = (busy_cnt != 3'd0);

  int n_checks = 0;
  int n_fail   = 0;
  int n_send   = 0;
  int n_cfg    = 0;
  int n_perr   = 0;
  logic [7:0] exp_q[$];
  logic prev_send = 1'b0;
  logic busy_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (busy) busy_seen = 1'b1;
      if (send) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_send: got %h, expected no send (t=%0t)", sbyte, $time);
        end else begin
          check("tx_byte", {24'h0, sbyte}, {24'h0, exp_q.pop_front()});
        end
        check("send_while_busy_low", {31'h0, busy}, 32'h0);
        check("no_back_to_back_send", {31'h0, prev_send}, 32'h0);
        check("busy_cycle_between_sends", {31'h0, busy_seen}, 32'h1);
        busy_seen = 1'b0;
        n_send++;
      end
      prev_send = send;
      if (cfg_update) n_cfg++;
      if (pkt_err) n_perr++;
    end else begin
      prev_send = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte     = b;
    rbyte_ready = 1'b1;
    @(negedge clk);
    rbyte_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Wait for every queued response byte, bounded, then let the FSM settle.
  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(20);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, c0, p0, waited;

    // ---- Reset values ----
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_freq_word", freq_word, 32'h0147AE14);
    check("rst_phase_ofs", phase_ofs, 32'h0);
    check("rst_amplitude", amplitude, 32'h00007FFF);
    check("rst_control",   control,   32'h0);
    check("rst_send",      {31'h0, send}, 32'h0);
    check("rst_sbyte",     {24'h0, sbyte}, 32'h0);
    check("rst_cfg_update",{31'h0, cfg_update}, 32'h0);
    check("rst_pkt_err",   {31'h0, pkt_err}, 32'h0);

    // ---- Write reg 0 ----
    s0 = n_send; c0 = n_cfg; p0 = n_perr;
    exp_q.push_back(8'h4B);
    send_rx(8'h57); send_rx(8'h00);
    send_rx(8'h12); send_rx(8'h34); send_rx(8'h56); send_rx(8'h78);
    drain("write0");
    check("wr0_freq_word", freq_word, 32'h12345678);
    check("wr0_amplitude", amplitude, 32'h00007FFF);
    check("wr0_cfg_pulses", n_cfg - c0, 1);
    check("wr0_sends", n_send - s0, 1);
    check("wr0_pkt_err", n_perr - p0, 0);

    // ---- Read reg 2 after reset ----
    do_reset();
    s0 = n_send; c0 = n_cfg;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
    send_rx(8'h52); send_rx(8'h02);
    drain("read2");
    check("rd2_sends", n_send - s0, 4);
    check("rd2_cfg_pulses", n_cfg - c0, 0);
    check("rd2_freq_word", freq_word, 32'h0147AE14);
    check("rd2_amplitude", amplitude, 32'h00007FFF);

    // ---- Bad address write then read ----
    s0 = n_send; c0 = n_cfg; p0 = n_perr;
    exp_q.push_back(8'h3F);
    send_rx(8'h57); send_rx(8'h05);
    send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hCC); send_rx(8'hDD);
    drain("badwr");
    check("badwr_pkt_err", n_perr - p0, 1);
    check("badwr_cfg", n_cfg - c0, 0);
    check("badwr_sends", n_send - s0, 1);
    check("badwr_freq_word", freq_word, 32'h0147AE14);
    check("badwr_phase_ofs", phase_ofs, 32'h0);
    check("badwr_control", control, 32'h0);
    s0 = n_send; p0 = n_perr;
    exp_q.push_back(8'h3F);
    send_rx(8'h52); send_rx(8'h05);
    drain("badrd");
    check("badrd_pkt_err", n_perr - p0, 1);
    check("badrd_sends", n_send - s0, 1);

    // ---- Timeout mid-packet ----
    s0 = n_send; c0 = n_cfg; p0 = n_perr;
    send_rx(8'h57); send_rx(8'h01); send_rx(8'h11); send_rx(8'h22);
    // Last byte sampled one cycle back; expiry pulse is visible 100 cycles on.
    waited = 0;
    while (!pkt_err && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    check("to_latency", waited, 100);
    idle(10);
    check("to_pkt_err", n_perr - p0, 1);
    check("to_sends", n_send - s0, 0);
    check("to_cfg", n_cfg - c0, 0);
    check("to_phase_ofs", phase_ofs, 32'h0);
    exp_q.push_back(8'h4B);
    send_rx(8'h57); send_rx(8'h01);
    send_rx(8'h00); send_rx(8'h00); send_rx(8'h00); send_rx(8'h01);
    drain("after_to");
    check("after_to_phase_ofs", phase_ofs, 32'h1);

    // ---- Address byte on the expiry cycle ----
    exp_q.push_back(8'h4B);
    send_rx(8'h57); send_rx(8'h03);
    send_rx(8'hA1); send_rx(8'hB2); send_rx(8'hC3); send_rx(8'hD4);
    drain("wr3");
    check("wr3_control", control, 32'hA1B2C3D4);
    s0 = n_send; p0 = n_perr;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    exp_q.push_back(8'hC3); exp_q.push_back(8'hD4);
    send_rx(8'h00);
    send_rx(8'h52);
    idle(TO - 2);
    send_rx(8'h03);
    drain("edge_rd");
    check("edge_sends", n_send - s0, 4);
    check("edge_pkt_err", n_perr - p0, 0);

    // ---- Reset during the second readback byte ----
    s0 = n_send;
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    send_rx(8'h52); send_rx(8'h03);
    waited = 0;
    while (n_send - s0 < 2 && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_two_sent", n_send - s0, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_send", {31'h0, send}, 32'h0);
    check("rst_mid_control", control, 32'h0);
    reset = 1'b0;
    idle(60);
    check("rst_mid_no_more_sends", n_send - s0, 2);
    check("rst_mid_freq_word", freq_word, 32'h0147AE14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
